// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO write-side arbiter.
//   arb_state_e : arbiter state encoding (IDLE, GRANT)
//   clog2_min1  : $clog2 clamped to at least 1. Counter and index vectors
//                 always get a legal, non-zero width, even for trivial
//                 parameter values.
package async_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2_min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/async_fifo_rr_pick.sv
// Combinational round-robin priority picker.
//   req       : per-requester valid vector
//   rr_ptr    : index where the search starts
//   pick      : first index i with req[i]=1, searching upward from rr_ptr
//               and wrapping modulo NUM_REQ (0 when nothing is valid)
//   any_valid : at least one bit of req is set
module async_fifo_rr_pick
    import async_fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int GID_W  = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   rr_ptr,
    output logic [GID_W-1:0]   pick,
    output logic               any_valid
);

    // Rotate the request vector so that bit k means "requester
    // (rr_ptr + k) mod NUM_REQ". A plain shift of the doubled vector does
    // this without a variable-index mux per bit.
    logic [NUM_REQ-1:0] rotated;
    assign rotated = NUM_REQ'({req, req} >> rr_ptr);

    always_comb begin
        int   idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                idx   = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                pick = GID_W'(idx);
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter that shares the FIFO write port among NUM_REQ
// requesters in the write clock domain. A requester holds the grant for up
// to MAX_BURST accepted beats. The arbiter releases it early when the
// requester drops valid. The granted requester's beat is written through to
// memory and to the write-pointer counter in the same cycle it is accepted.
//   clk, reset_n      : write clock, asynchronous active-low reset
//   req_valid/data    : per-requester beat valid and data (slice i = req i)
//   req_ready         : beat of requester i accepted when valid is also high
//   fifo_full         : backpressure from the write-side full logic
//   wr_en, wr_data    : memory write strobe and data
//   counter_incr/en   : write-pointer gray counter control
//   grant_id, busy    : current grant index, grant-held flag
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int GID_W     = clog2_min1(NUM_REQ),
    localparam int CNT_W     = clog2_min1(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          counter_incr,
    output logic                          counter_en,
    output logic [GID_W-1:0]              grant_id,
    output logic                          busy
);

    arb_state_e       state_reg, state_next;
    logic [GID_W-1:0] grant_id_reg, grant_id_next;
    logic [GID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign data_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [GID_W-1:0] pick;
    logic [GID_W-1:0] pick_succ;
    logic             any_valid;

    async_fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .pick      (pick),
        .any_valid (any_valid)
    );

    // Next search start is the requester after the one just picked.
    assign pick_succ = (pick == GID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

    logic in_grant;
    logic granted_valid;
    logic accept;
    logic burst_last;
    logic rel_grant;

    assign in_grant      = (state_reg == GRANT);
    assign granted_valid = req_valid[grant_id_reg];
    assign accept        = in_grant && granted_valid && !fifo_full;
    assign burst_last    = (beat_cnt_reg == CNT_W'(MAX_BURST - 1));
    // A dropped valid releases even while full; a full FIFO with valid
    // held keeps the grant and freezes the beat count.
    assign rel_grant     = in_grant && ((accept && burst_last) || !granted_valid);

    // The write port follows the accept decision combinationally, so the
    // beat lands at the pre-increment address while the pointer advances.
    always_comb begin
        req_ready = '0;
        if (in_grant) begin
            req_ready[grant_id_reg] = !fifo_full;
        end
    end

    assign wr_en        = accept;
    assign counter_incr = accept;
    assign wr_data      = accept ? data_slice[grant_id_reg] : '0;
    assign counter_en   = in_grant;
    assign busy         = in_grant;
    assign grant_id     = grant_id_reg;

    always_comb begin
        state_next    = state_reg;
        grant_id_next = grant_id_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    state_next    = GRANT;
                    grant_id_next = pick;
                    rr_ptr_next   = pick_succ;
                    beat_cnt_next = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
                if (rel_grant) begin
                    beat_cnt_next = '0;
                    if (any_valid) begin
                        // Back-to-back re-grant, no idle bubble.
                        grant_id_next = pick;
                        rr_ptr_next   = pick_succ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            grant_id_reg <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_id_reg <= grant_id_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed testbench for async_fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// MAX_BURST=4). Inputs change on the falling edge; outputs are checked 1
// time unit later, well away from the rising edge.
module tb_async_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int MB      = 4;

    logic                  clk;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  fifo_full;
    logic                  wr_en;
    logic [DW-1:0]         wr_data;
    logic                  counter_incr;
    logic                  counter_en;
    logic [1:0]            grant_id;
    logic                  busy;

    async_fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .counter_incr (counter_incr),
        .counter_en   (counter_en),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int incr_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_data(input int idx, input logic [DW-1:0] val);
        req_data[idx*DW +: DW] = val;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_wren"},  32'(wr_en), 32'd0);
        chk({tag, "_incr"},  32'(counter_incr), 32'd0);
        chk({tag, "_cen"},   32'(counter_en), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_wdata"}, 32'(wr_data), 32'd0);
    endtask

    task automatic chk_beat(input string tag, input int gid, input logic [DW-1:0] data);
        chk({tag, "_gid"},   32'(grant_id), 32'(gid));
        chk({tag, "_wren"},  32'(wr_en), 32'd1);
        chk({tag, "_incr"},  32'(counter_incr), 32'd1);
        chk({tag, "_wdata"}, 32'(wr_data), 32'(data));
        chk({tag, "_ready"}, 32'(req_ready), 32'd1 << gid);
        chk({tag, "_busy"},  32'(busy), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        step();
        reset_n = 1'b0;
        #1;
        chk_idle(tag);
        chk({tag, "_gid"}, 32'(grant_id), 32'd0);
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        #2;
        chk_idle("por");
        chk("por_gid", 32'(grant_id), 32'd0);
        step();
        reset_n = 1'b1;

        // Single requester, three beats, then valid drops.
        step();
        req_valid = 4'b0001;
        set_data(0, 8'hA1);
        #1 chk_idle("t1_arb");
        step(); #1 chk_beat("t1_b1", 0, 8'hA1);
        step(); set_data(0, 8'hA2); #1 chk_beat("t1_b2", 0, 8'hA2);
        step(); set_data(0, 8'hA3); #1 chk_beat("t1_b3", 0, 8'hA3);
        step(); req_valid = 4'b0000;
        #1;
        chk("t1_drop_wren", 32'(wr_en), 32'd0);
        chk("t1_drop_busy", 32'(busy), 32'd1);
        step(); #1 chk_idle("t1_idle");

        // All requesters valid: 0,1,2,3,0 with four beats each, no bubble.
        do_reset("t2_rst");
        step();
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'hB0 + 8'(i));
        #1 chk_idle("t2_arb");
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < MB; b++) begin
                step(); #1;
                chk_beat($sformatf("t2_g%0d_b%0d", g, b), g % NUM_REQ, 8'hB0 + 8'(g % NUM_REQ));
            end
        end
        step(); req_valid = 4'b0000;
        #1;
        chk("t2_next_gid", 32'(grant_id), 32'd1);
        chk("t2_drop_wren", 32'(wr_en), 32'd0);
        step(); #1 chk_idle("t2_idle");

        // Requester 2 stalled by fifo_full after beat 2 for five cycles.
        do_reset("t3_rst");
        step();
        req_valid = 4'b0100;
        set_data(2, 8'hC1);
        #1 chk_idle("t3_arb");
        step(); #1 chk_beat("t3_b1", 2, 8'hC1);
        step(); set_data(2, 8'hC2); #1 chk_beat("t3_b2", 2, 8'hC2);
        step(); fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t3_full%0d_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("t3_full%0d_wren", k), 32'(wr_en), 32'd0);
            chk($sformatf("t3_full%0d_incr", k), 32'(counter_incr), 32'd0);
            chk($sformatf("t3_full%0d_wdata", k), 32'(wr_data), 32'd0);
            chk($sformatf("t3_full%0d_gid", k), 32'(grant_id), 32'd2);
            chk($sformatf("t3_full%0d_busy", k), 32'(busy), 32'd1);
            chk($sformatf("t3_full%0d_beats", k), 32'(dut.beat_cnt_reg), 32'd2);
            step();
        end
        fifo_full = 1'b0;
        set_data(2, 8'hC3);
        #1 chk_beat("t3_b3", 2, 8'hC3);
        step(); set_data(2, 8'hC4); #1 chk_beat("t3_b4", 2, 8'hC4);
        step(); req_valid = 4'b0000;
        #1;
        chk("t3_rel_beats", 32'(dut.beat_cnt_reg), 32'd0);
        chk("t3_rel_wren", 32'(wr_en), 32'd0);
        step(); #1 chk_idle("t3_idle");

        // Only requester 1 valid for ten beats: re-granted without bubble.
        do_reset("t4_rst");
        step();
        req_valid = 4'b0010;
        set_data(1, 8'hD0);
        #1 chk_idle("t4_arb");
        incr_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            set_data(1, 8'hD0 + 8'(k));
            #1;
            chk_beat($sformatf("t4_b%0d", k), 1, 8'hD0 + 8'(k));
            incr_cnt += int'(counter_incr);
        end
        chk("t4_incr_pulses", 32'(incr_cnt), 32'd10);
        step(); req_valid = 4'b0000;
        #1 chk("t4_drop_wren", 32'(wr_en), 32'd0);
        step(); #1 chk_idle("t4_idle");

        // Reset mid-burst, then arbitration restarts from index 0.
        do_reset("t5_rst");
        step();
        req_valid = 4'b1010;
        set_data(1, 8'hE1);
        set_data(3, 8'hE3);
        #1 chk_idle("t5_arb");
        step(); #1 chk_beat("t5_b1", 1, 8'hE1);
        step(); #1 chk_beat("t5_b2_pending", 1, 8'hE1);
        reset_n = 1'b0;
        #1;
        chk_idle("t5_async_rst");
        chk("t5_async_gid", 32'(grant_id), 32'd0);
        step(); reset_n = 1'b1;
        #1 chk_idle("t5_post_rst");
        step(); #1 chk_beat("t5_regrant", 1, 8'hE1);
        step(); req_valid = 4'b0000;
        step(); #1 chk_idle("t5_idle");

        // rr_ptr=3 with requesters 0 and 2 valid: pick wraps to 0, then 2.
        do_reset("t6_rst");
        step();
        req_valid = 4'b0100;
        set_data(2, 8'hF2);
        #1 chk_idle("t6_arb");
        step(); #1 chk_beat("t6_g2", 2, 8'hF2);
        step(); req_valid = 4'b0000;
        #1 chk("t6_drop_wren", 32'(wr_en), 32'd0);
        step(); req_valid = 4'b0101;
        set_data(0, 8'hF0);
        #1 chk_idle("t6_arb2");
        step(); #1 chk_beat("t6_g0", 0, 8'hF0);
        step(); req_valid = 4'b0100;
        #1;
        chk("t6_rel_gid", 32'(grant_id), 32'd0);
        chk("t6_rel_wren", 32'(wr_en), 32'd0);
        step(); #1 chk_beat("t6_g2b", 2, 8'hF2);
        step(); req_valid = 4'b0000;
        step(); #1 chk_idle("t6_idle");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO among NUM_REQ write-domain requesters. It grants one requester at a time for a burst of up to MAX_BURST beats and muxes that requester's data onto the FIFO write port. It drives counter_incr/counter_en of the write-side gray-code pointer counter and honours fifo_full backpressure. Sits entirely in the write clock domain, between the requesters and the write-pointer counter and memory.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, width of each write data beat
MAX_BURST, 4, maximum accepted beats per grant before forced re-arbitration (1..256)

Ports:
clk  input  1  write-domain clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester beat accepted this cycle when valid is also high
fifo_full  input  1  FIFO full flag from write-side full logic
wr_en  output  1  memory write strobe at the current write address
wr_data  output  DATA_WIDTH  memory write data
counter_incr  output  1  write-pointer counter increment request
counter_en  output  1  write-pointer counter enable
grant_id  output  $clog2(NUM_REQ)  index of the currently granted requester
busy  output  1  high while a grant is held

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Registered state: state {IDLE, GRANT}, grant_id, rr_ptr (next search start), beat_cnt (width $clog2(MAX_BURST+1)).
- Reset values: state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0. Outputs: req_ready=0, wr_en=0, counter_incr=0, counter_en=0, busy=0, wr_data=0.
- Pick function: the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
- IDLE: if any req_valid is high, register grant_id=pick, rr_ptr=(pick+1) mod NUM_REQ, beat_cnt=0, and go to GRANT. No beat is accepted in IDLE, so arbitration latency is 1 cycle.
- GRANT, combinational outputs:
  - req_ready[grant_id] = !fifo_full; all other bits are 0.
  - accept = req_valid[grant_id] && !fifo_full.
  - wr_en = counter_incr = accept.
  - wr_data = req_data slice of grant_id when accept, else 0.
  - counter_en = busy = 1.
  - Zero latency: the beat is written at the pre-increment address in the same cycle the pointer advances.
- GRANT, on accept: beat_cnt increments.
- GRANT, release occurs when either:
  - accept happens and beat_cnt==MAX_BURST-1 (burst exhausted), or
  - req_valid[grant_id]==0 (requester dropped, with or without full).
- On release:
  - beat_cnt=0.
  - If any req_valid is high in the release cycle, re-grant directly to pick (GRANT->GRANT, no bubble) and update rr_ptr. The pick may return the same requester if it is the only one valid.
  - Otherwise go to IDLE.
- fifo_full high in GRANT with valid held: no accept, grant held indefinitely, beat_cnt frozen.
- Requester i must hold req_data stable while req_valid[i]=1 and it has not been accepted.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0. The pointer counter's own rollover is transparent to this block.
- Reset mid-burst: return immediately to reset values. A beat that was not accepted is not written.
- Simultaneous events: when release and a new pick coincide, the new grant_id is visible the following cycle.

Decomposition:
- async_fifo_pkg: arb_state_e enum {IDLE, GRANT}; the function computing $clog2 widths for grant_id and beat_cnt.
- Sub-module async_fifo_rr_pick: combinational round-robin priority picker. Inputs req vector and rr_ptr; outputs pick index and any_valid. It is instantiated once.

Test Plan:
- Reset then req_valid=4'b0001 with 3 beats 0xA1,0xA2,0xA3: IDLE 1 cycle, then grant_id=0, wr_en/counter_incr high for 3 consecutive cycles with wr_data A1,A2,A3; valid drops, so state goes to IDLE and busy=0.
- req_valid=4'b1111 held continuously, MAX_BURST=4: grants rotate 0,1,2,3,0, each with exactly 4 beats, no idle bubble between grants.
- Requester 2 granted, fifo_full asserted after beat 2 for 5 cycles: req_ready=0, wr_en=0, grant_id stays 2, beat_cnt stays 2; on full release, beats 3-4 are written and the requester is then released.
- Only requester 1 valid, 10 beats, MAX_BURST=4: re-granted to 1 after beats 4 and 8 with no bubble; 10 writes total, counter_incr pulses 10 times.
- reset_n asserted mid-burst (after beat 1 of 4): all outputs 0 asynchronously; after release the first grant goes to the lowest valid index starting from 0.
- rr_ptr=3, req_valid=4'b0101: pick=0; after requester 0 releases with 2 still valid, grant goes to 2.
